cnt_accum: RTL and testbench
============================

// Module: cnt_accum
// PURPOSE
//  Streaming accumulator placed directly downstream of the cnt_bits popcount stage.
//  Each input beat carries one population count. The block sums the counts over a
//  frame terminated by in_last. It then presents the frame total, the beat count and
//  a saturation flag on a valid/ready output port. The downstream consumer is
//  occupancy/statistics logic.
// PARAMETERS
//  IN     128               width of the vector counted upstream; legal in_cnt range is 0..IN
//  CW     $clog2(IN)+1      in_cnt width (matches the cnt_bits output width); derived, do not override
//  ACC_W  16                out_sum width
//  BEAT_W 8                 out_beats width
// PORTS
//  clk        in   1       clock, rising edge
//  reset_     in   1       asynchronous active-low reset
//  clear      in   1       synchronous frame abort, highest priority
//  in_valid   in   1       in_cnt/in_last valid
//  in_ready   out  1       block accepts a beat
//  in_cnt     in   CW      popcount of one beat
//  in_last    in   1       beat is the final beat of the frame
//  out_valid  out  1       frame result valid
//  out_ready  in   1       consumer accepts the result
//  out_sum    out  ACC_W   saturating sum of in_cnt over the frame
//  out_beats  out  BEAT_W  number of beats in the frame, saturating
//  out_sat    out  1       sum or beat counter saturated during the frame
// BEHAVIOUR
//  - Reset (reset_=0, async):
//    - state=ACC.
//    - sum, beats, sat = 0; out_valid=0; in_ready=0.
//    - in_ready rises on the first clk edge after reset_ deasserts.
//  - States: ACC (accumulating) and HOLD (result presented).
//    - in_ready = registered (state==ACC).
//    - out_valid = registered (state==HOLD).
//  - Accept: in_valid & in_ready.
//    - The effective count is in_cnt clamped to IN; values above IN are illegal and are clamped.
//    - sum <= min(sum + cnt, 2^ACC_W-1). sat is set sticky if the clamp to 2^ACC_W-1 engages.
//    - beats <= min(beats + 1, 2^BEAT_W-1). sat is set sticky if this clamp engages.
//  - Accept with in_last: the result includes that beat.
//    - Next cycle: state=HOLD, out_valid=1, in_ready=0.
//    - Latency from the last accept to out_valid is 1 cycle.
//  - HOLD:
//    - out_sum, out_beats and out_sat stay stable until the handshake.
//    - in_valid is ignored.
//  - out_valid & out_ready:
//    - Next cycle: sum, beats and sat are 0, state=ACC, in_ready=1.
//    - Exactly one bubble cycle separates consecutive frames.
//  - Single-beat frame (in_last on the first beat): legal; out_beats=1.
//  - Zero-count beats still increment beats.
//  - clear=1 at a clock edge, in any state:
//    - Next cycle: sum, beats, sat = 0; state=ACC; out_valid=0; in_ready=1.
//    - A beat or out handshake in the same cycle is discarded.
//  - Reset mid-frame discards the partial frame with no output.
//  - out_sum, out_beats and out_sat are registered; they are 0 after reset and after clear.
// TESTING
//  - Reset then 4 beats {3,0,128,5}, last on the 4th, out_ready=1.
//    -> out_valid 1 cycle after the 4th accept; out_sum=136, out_beats=4, out_sat=0.
//  - Hold out_ready=0 for 10 cycles in HOLD while in_valid=1.
//    -> in_ready=0 throughout; outputs stable; no beats absorbed.
//    -> After out_ready=1, in_ready=1 the next cycle.
//  - ACC_W=8, 3 beats of 128 -> out_sum=255, out_sat=1.
//    -> The next frame {1}, last gives out_sum=1, out_sat=0.
//  - BEAT_W=8, 300 beats of 1 with last on #300 -> out_beats=255, out_sum=300, out_sat=1.
//  - Beats {10,20}, clear on the 3rd cycle with a concurrent valid beat of 7, then {4}, last.
//    -> out_sum=4, out_beats=1.
//  - Single beat in_cnt=200 (>IN), last -> clamped: out_sum=128, out_beats=1.
//    - Also: assert reset_ mid-frame -> out_valid=0, in_ready=0 immediately.

Source files
------------

// File: rtl/cnt_accum.sv
// -----------------------------------------------------------------------------
// cnt_accum
//   Frame accumulator that sits after the cnt_bits popcount stage. It sums the
//   per-beat population counts of a frame (terminated by in_last) and presents
//   the saturating total, the saturating beat count and a sticky saturation
//   flag on a valid/ready result port.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   ACC   | accumulating beats; in_ready=1 (except the first cycle after reset)
//   HOLD  | frame result presented on out_*; input side stalled
//
// Ports
//   clk        clock, rising edge
//   reset_     asynchronous active-low reset
//   clear      synchronous frame abort, overrides everything else
//   in_valid   in_cnt / in_last valid
//   in_ready   block accepts a beat (registered)
//   in_cnt     popcount of one beat, 0..IN (larger values are clamped to IN)
//   in_last    final beat of the frame
//   out_valid  frame result valid (registered)
//   out_ready  consumer accepts the result
//   out_sum    saturating sum of in_cnt over the frame
//   out_beats  saturating number of beats in the frame
//   out_sat    sum or beat counter saturated during the frame
// -----------------------------------------------------------------------------
module cnt_accum #(
    parameter int IN     = 128,
    parameter int CW     = $clog2(IN) + 1,
    parameter int ACC_W  = 16,
    parameter int BEAT_W = 8
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW-1:0]     in_cnt,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [BEAT_W-1:0] out_beats,
    output logic              out_sat
);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // One spare bit above the wider operand so the overflow is observable.
    localparam int SW = ((ACC_W > CW) ? ACC_W : CW) + 1;

    localparam logic [CW-1:0] CNT_MAX = CW'(IN);
    localparam logic [SW-1:0] SUM_MAX = SW'({ACC_W{1'b1}});

    state_t            state;
    logic              accept;
    logic              handshake;
    logic [CW-1:0]     cnt_eff;
    logic [SW-1:0]     sum_wide;
    logic              sum_ovf;
    logic [ACC_W-1:0]  sum_next;
    logic              beat_ovf;
    logic [BEAT_W-1:0] beats_next;

    assign accept    = in_valid & in_ready;
    assign handshake = out_valid & out_ready;

    assign cnt_eff    = (in_cnt > CNT_MAX) ? CNT_MAX : in_cnt;
    assign sum_wide   = SW'(out_sum) + SW'(cnt_eff);
    assign sum_ovf    = (sum_wide > SUM_MAX);
    assign sum_next   = sum_ovf ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    // The beat counter can only overflow when it is already at its maximum.
    assign beat_ovf   = &out_beats;
    assign beats_next = beat_ovf ? out_beats : out_beats + BEAT_W'(1);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state     <= ACC;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_beats <= '0;
            out_sat   <= 1'b0;
        end else if (clear) begin
            state     <= ACC;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_beats <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    // Also raises in_ready on the first edge after reset.
                    in_ready <= 1'b1;
                    if (accept) begin
                        out_sum   <= sum_next;
                        out_beats <= beats_next;
                        out_sat   <= out_sat | sum_ovf | beat_ovf;
                        if (in_last) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (handshake) begin
                        state     <= ACC;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        out_sum   <= '0;
                        out_beats <= '0;
                        out_sat   <= 1'b0;
                    end
                end
                default: begin
                    state     <= ACC;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnt_accum.sv
module tb_cnt_accum;

    localparam int IN = 128;
    localparam int CW = $clog2(IN) + 1;

    logic          clk = 1'b0;
    logic          reset_;
    logic          clear;
    logic          in_valid;
    logic [CW-1:0] in_cnt;
    logic          in_last;
    logic          out_ready;

    logic          in_ready, out_valid, out_sat;
    logic [15:0]   out_sum;
    logic [7:0]    out_beats;

    logic          r8, v8, s8_sat;
    logic [7:0]    s8_sum;
    logic [7:0]    s8_beats;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    cnt_accum #(.IN(IN), .ACC_W(16), .BEAT_W(8)) dut (
        .clk(clk), .reset_(reset_), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_cnt(in_cnt), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_beats(out_beats), .out_sat(out_sat)
    );

    // Narrow-accumulator instance sharing the same stimulus.
    cnt_accum #(.IN(IN), .ACC_W(8), .BEAT_W(8)) dut8 (
        .clk(clk), .reset_(reset_), .clear(clear),
        .in_valid(in_valid), .in_ready(r8), .in_cnt(in_cnt), .in_last(in_last),
        .out_valid(v8), .out_ready(out_ready),
        .out_sum(s8_sum), .out_beats(s8_beats), .out_sat(s8_sat)
    );

    // Called and returns at a falling edge; one beat is accepted on the
    // rising edge in between.
    task automatic send(input int c, input bit last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_cnt   = CW'(c);
        in_last  = last;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL send_timeout: in_ready got %0b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        reset_ = 1'b0; clear = 1'b0; in_valid = 1'b0; in_cnt = '0;
        in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({in_ready, out_valid, out_sum, out_beats, out_sat} !== 27'd0)
            $display("FAIL reset_state: got rdy=%0b vld=%0b sum=%0d beats=%0d sat=%0b required all 0",
                     in_ready, out_valid, out_sum, out_beats, out_sat);
        else n_pass++;
        reset_ = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL reset_release_rdy: got %0b required 0", in_ready);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_first_edge_rdy: got %0b required 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(3, 0); send(0, 0); send(128, 0); send(5, 1);
        n_total++;
        if (out_valid !== 1'b1) $display("FAIL basic_valid: got %0b required 1", out_valid);
        else n_pass++;
        n_total++;
        if (out_sum !== 16'd136 || out_beats !== 8'd4 || out_sat !== 1'b0)
            $display("FAIL basic_result: got sum=%0d beats=%0d sat=%0b required 136 4 0",
                     out_sum, out_beats, out_sat);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL basic_hold_rdy: got %0b required 0", in_ready);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 16'd0 || out_beats !== 8'd0)
            $display("FAIL basic_after_hs: got vld=%0b rdy=%0b sum=%0d beats=%0d required 0 1 0 0",
                     out_valid, in_ready, out_sum, out_beats);
        else n_pass++;
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        send(7, 0); send(9, 1);
        in_valid = 1'b1; in_cnt = CW'(50); in_last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 16'd16 ||
                out_beats !== 8'd2 || out_sat !== 1'b0)
                $display("FAIL hold_cycle%0d: got rdy=%0b vld=%0b sum=%0d beats=%0d sat=%0b required 0 1 16 2 0",
                         i, in_ready, out_valid, out_sum, out_beats, out_sat);
            else n_pass++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 16'd0)
            $display("FAIL hold_release: got rdy=%0b vld=%0b sum=%0d required 1 0 0",
                     in_ready, out_valid, out_sum);
        else n_pass++;
    endtask

    task automatic test_sum_sat();
        out_ready = 1'b1;
        send(128, 0); send(128, 0); send(128, 1);
        n_total++;
        if (v8 !== 1'b1 || s8_sum !== 8'd255 || s8_sat !== 1'b1 || s8_beats !== 8'd3)
            $display("FAIL sum_sat8: got vld=%0b sum=%0d beats=%0d sat=%0b required 1 255 3 1",
                     v8, s8_sum, s8_beats, s8_sat);
        else n_pass++;
        n_total++;
        if (out_sum !== 16'd384 || out_sat !== 1'b0)
            $display("FAIL sum_wide16: got sum=%0d sat=%0b required 384 0", out_sum, out_sat);
        else n_pass++;
        send(1, 1);
        n_total++;
        if (v8 !== 1'b1 || s8_sum !== 8'd1 || s8_sat !== 1'b0 || s8_beats !== 8'd1)
            $display("FAIL sum_sat8_next: got vld=%0b sum=%0d beats=%0d sat=%0b required 1 1 1 0",
                     v8, s8_sum, s8_beats, s8_sat);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_beat_sat();
        out_ready = 1'b1;
        for (int i = 1; i <= 300; i++) send(1, i == 300);
        n_total++;
        if (out_valid !== 1'b1 || out_beats !== 8'd255 || out_sum !== 16'd300 || out_sat !== 1'b1)
            $display("FAIL beat_sat: got vld=%0b beats=%0d sum=%0d sat=%0b required 1 255 300 1",
                     out_valid, out_beats, out_sum, out_sat);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_clear();
        out_ready = 1'b1;
        send(10, 0); send(20, 0);
        in_valid = 1'b1; in_cnt = CW'(7); clear = 1'b1;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        n_total++;
        if (out_sum !== 16'd0 || out_beats !== 8'd0 || in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL clear_acc: got sum=%0d beats=%0d rdy=%0b vld=%0b required 0 0 1 0",
                     out_sum, out_beats, in_ready, out_valid);
        else n_pass++;
        send(4, 1);
        n_total++;
        if (out_valid !== 1'b1 || out_sum !== 16'd4 || out_beats !== 8'd1)
            $display("FAIL clear_next_frame: got vld=%0b sum=%0d beats=%0d required 1 4 1",
                     out_valid, out_sum, out_beats);
        else n_pass++;
        @(negedge clk);
        out_ready = 1'b0;
        send(5, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 16'd0 || out_beats !== 8'd0)
            $display("FAIL clear_hold: got vld=%0b rdy=%0b sum=%0d beats=%0d required 0 1 0 0",
                     out_valid, in_ready, out_sum, out_beats);
        else n_pass++;
    endtask

    task automatic test_clamp();
        out_ready = 1'b1;
        send(200, 1);
        n_total++;
        if (out_valid !== 1'b1 || out_sum !== 16'd128 || out_beats !== 8'd1 || out_sat !== 1'b0)
            $display("FAIL clamp: got vld=%0b sum=%0d beats=%0d sat=%0b required 1 128 1 0",
                     out_valid, out_sum, out_beats, out_sat);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        out_ready = 1'b1;
        send(3, 0); send(4, 0);
        reset_ = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_sum !== 16'd0 || out_beats !== 8'd0)
            $display("FAIL reset_mid: got vld=%0b rdy=%0b sum=%0d beats=%0d required 0 0 0 0",
                     out_valid, in_ready, out_sum, out_beats);
        else n_pass++;
        @(negedge clk);
        reset_ = 1'b1;
        @(negedge clk);
        send(2, 1);
        n_total++;
        if (out_valid !== 1'b1 || out_sum !== 16'd2 || out_beats !== 8'd1)
            $display("FAIL reset_mid_next: got vld=%0b sum=%0d beats=%0d required 1 2 1",
                     out_valid, out_sum, out_beats);
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_sum_sat();
        test_beat_sat();
        test_clear();
        test_clamp();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
